dec3to8_seq: RTL
================

DEC3TO8_SEQ -- requirements
Module: dec3to8_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 4: code FIFO depth, power of two, at least 2.
REQ-002 SHALL have parameter HOLD_W, default 4: width of hold_len.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port EN, input, 1 bit: block enable; low flushes the block.
REQ-006 SHALL have port valid, input, 1 bit: a code is offered on Y.
REQ-007 SHALL have port Y, input, 3 bits: binary code 0..7, matching the 8-to-3 priority encoder output format.
REQ-008 SHALL have port ready, output, 1 bit: the block can accept a code this cycle.
REQ-009 SHALL have port hold_len, input, HOLD_W bits: a code is held for hold_len+1 cycles.
REQ-010 SHALL have port Dout, output, 8 bits: one-hot decoded output, or all zero when idle.
REQ-011 SHALL have port busy, output, 1 bit: the FSM is in HOLD.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when a code's hold completes.

Function
REQ-013 SHALL compute ready = EN && (FIFO count != DEPTH) from registered state only, with no path from valid or Y.
REQ-014 SHALL push Y into the FIFO on an edge where valid && ready; codes offered while ready=0 SHALL be ignored.
REQ-015 SHALL use a two-state FSM: IDLE and HOLD.
REQ-016 IDLE with FIFO non-empty and EN=1 SHALL, at the next edge: pop the head, set Dout = 8'b1 << code, load the hold counter with hold_len, and enter HOLD.
REQ-017 SHALL give a latency of one edge from push into an empty FIFO in IDLE until Dout shows the code (accept at edge k, Dout valid after edge k+1); there is no bypass.
REQ-018 In HOLD, the hold counter SHALL decrement each cycle, and Dout SHALL stay constant for exactly hold_len+1 cycles.
REQ-019 On the last HOLD cycle (counter=0), done SHALL be 1 for that cycle only.
REQ-020 On the last HOLD cycle with the FIFO non-empty, the block SHALL pop and load the next code at the next edge, with no zero gap and staying in HOLD.
REQ-021 On the last HOLD cycle with the FIFO empty, the block SHALL set Dout=0 at the next edge and go to IDLE.
REQ-022 A push and a pop on the same edge SHALL both take effect, with the count unchanged.
REQ-023 The FIFO SHALL preserve order, with read and write pointers wrapping modulo DEPTH.
REQ-024 hold_len SHALL be sampled only at load; changes during HOLD SHALL have no effect.
REQ-025 EN=0 seen at an edge SHALL clear Dout to 0, empty the FIFO, clear the counter and go to IDLE; done SHALL not pulse, and this overrides any push or pop that cycle.
REQ-026 Dout SHALL always be zero or exactly one-hot; busy SHALL equal (state == HOLD).

Reset
REQ-027 While rst_n=0, asynchronously: Dout=0, busy=0, done=0, state=IDLE, FIFO pointers and count=0, hold counter=0.
REQ-028 While rst_n=0, ready SHALL be 0.
REQ-029 After rst_n rises, ready SHALL follow REQ-013 from the first cycle.
REQ-030 Reset asserted mid-HOLD SHALL drop Dout immediately, with no done pulse.

Structure
REQ-031 Package dec_pkg SHALL hold: state enum (IDLE, HOLD), defaults for DEPTH and HOLD_W, and the 3-bit code typedef.
REQ-032 The FIFO SHALL be one sub-module, code_fifo (DEPTH x 3 bits, with push, pop, full, empty and count), with the FSM and decode kept in dec3to8_seq.
REQ-033 All outputs except ready SHALL be registered.

Verification
REQ-034 Reset then EN=1, hold_len=2, single push Y=5 at edge k -> Dout=8'h20 after edges k+1..k+3, done=1 in the cycle after edge k+3, Dout=0 after edge k+4.
REQ-035 Back-to-back pushes Y=0,7,3 with hold_len=0 -> Dout sequence 01, 80, 08 on consecutive cycles with no zero gap, three done pulses, then Dout=0.
REQ-036 Push 5 codes (DEPTH=4) while the first is in a long hold (hold_len=15) -> ready=0 after the 4th FIFO entry and the 5th offer is ignored; exactly 4 codes are then emitted in order.
REQ-037 EN dropped mid-HOLD with 2 codes queued -> next edge Dout=0, busy=0, FIFO empty, no done; re-enabling emits nothing until new pushes.
REQ-038 rst_n asserted asynchronously mid-HOLD (between edges) -> Dout=0 and ready=0 immediately; after release, a push of Y=1 emits 8'h02.
REQ-039 Random valid/Y/hold_len with EN toggling, checked against a reference model -> Dout is always one-hot or zero, order is preserved, and the done count equals codes emitted to completion.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared types and defaults for the sequenced 3-to-8 decoder.
package dec_pkg;

  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned HOLD_W_DEF = 4;

  typedef logic [2:0] code_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [7:0] decode(input code_t c);
    return 8'(8'd1 << c);
  endfunction

endpackage

// File: rtl/code_fifo.sv
// Small circular FIFO of 3-bit codes; flush empties it and overrides push/pop.
module code_fifo
  import dec_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  code_t                  wdata,
  input  logic                   pop,
  output code_t                  rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  code_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_q];
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + PTR_W'(1);
      if (pop_ok)  rd_q <= rd_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/dec3to8_seq.sv
// Queued 3-to-8 decoder: each accepted code is shown one-hot on Dout for hold_len+1 cycles.
module dec3to8_seq
  import dec_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned HOLD_W = HOLD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EN,
  input  logic              valid,
  input  logic [2:0]        Y,
  output logic              ready,
  input  logic [HOLD_W-1:0] hold_len,
  output logic [7:0]        Dout,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  state_t            state_q, state_n;
  logic [HOLD_W-1:0] hold_q, hold_n;
  logic [7:0]        dout_n;
  logic              done_n;
  code_t             head;
  logic              full, empty, push, pop;
  logic [CNT_W-1:0]  count;

  // Acceptance depends only on registered occupancy; held low during reset.
  assign ready = rst_n && EN && (count != CNT_W'(DEPTH));
  assign push  = valid && ready && !full;
  assign busy  = (state_q == HOLD);

  code_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (!EN),
    .push  (push),
    .wdata (code_t'(Y)),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      Dout    <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_n;
      hold_q  <= hold_n;
      Dout    <= dout_n;
      done    <= done_n;
    end
  end

  // Next-state: load from FIFO when idle or on the last hold cycle, otherwise count down.
  always_comb begin
    state_n = state_q;
    hold_n  = hold_q;
    dout_n  = Dout;
    done_n  = 1'b0;
    pop     = 1'b0;
    if (!EN) begin
      state_n = IDLE;
      hold_n  = '0;
      dout_n  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            dout_n  = decode(head);
            hold_n  = hold_len;
            state_n = HOLD;
          end
        end
        HOLD: begin
          if (hold_q != '0) begin
            hold_n = hold_q - HOLD_W'(1);
          end else if (!empty) begin
            pop    = 1'b1;
            dout_n = decode(head);
            hold_n = hold_len;
          end else begin
            dout_n  = '0;
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
          dout_n  = '0;
          hold_n  = '0;
        end
      endcase
      done_n = (state_n == HOLD) && (hold_n == '0);
    end
  end

endmodule
